instr_decode_stage: RTL and testbench

//  RV32I decode stage sitting directly upstream of the register file.

---
 rtl/instr_decode_stage_pkg.sv | 82 ++++++++
 rtl/instr_decode_stage_imm_gen.sv | 29 ++
 rtl/instr_decode_stage.sv | 105 ++++++++++
 tb/tb_instr_decode_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcode constants,
// opclass codes, immediate-format selects and the per-opcode decode table.
`ifndef INSTR_DECODE_STAGE_PKG_SV
`define INSTR_DECODE_STAGE_PKG_SV
package instr_decode_stage_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned CLS_W = 4;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MISC   = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [CLS_W-1:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_MISC    = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    opclass_e cls;
    imm_fmt_e fmt;
    logic     rs1_used;
    logic     rs2_used;
    logic     writes_rd;
    logic     illegal;
  } op_info_t;

  // Per-opcode decode table; unknown opcodes come back illegal with no immediate.
  function automatic op_info_t decode_opcode(input logic [OPC_W-1:0] opc);
    op_info_t info;
    info.cls       = CLS_ILLEGAL;
    info.fmt       = IMM_NONE;
    info.rs1_used  = 1'b1;
    info.rs2_used  = 1'b0;
    info.writes_rd = 1'b0;
    info.illegal   = 1'b0;
    case (opc)
      OPC_LUI:    begin info.cls = CLS_LUI;    info.fmt = IMM_U; info.rs1_used = 1'b0; info.writes_rd = 1'b1; end
      OPC_AUIPC:  begin info.cls = CLS_AUIPC;  info.fmt = IMM_U; info.rs1_used = 1'b0; info.writes_rd = 1'b1; end
      OPC_JAL:    begin info.cls = CLS_JAL;    info.fmt = IMM_J; info.rs1_used = 1'b0; info.writes_rd = 1'b1; end
      OPC_JALR:   begin info.cls = CLS_JALR;   info.fmt = IMM_I; info.writes_rd = 1'b1; end
      OPC_BRANCH: begin info.cls = CLS_BRANCH; info.fmt = IMM_B; info.rs2_used = 1'b1; end
      OPC_LOAD:   begin info.cls = CLS_LOAD;   info.fmt = IMM_I; info.writes_rd = 1'b1; end
      OPC_STORE:  begin info.cls = CLS_STORE;  info.fmt = IMM_S; info.rs2_used = 1'b1; end
      OPC_OPIMM:  begin info.cls = CLS_OPIMM;  info.fmt = IMM_I; info.writes_rd = 1'b1; end
      OPC_OP:     begin info.cls = CLS_OP;     info.rs2_used = 1'b1; info.writes_rd = 1'b1; end
      OPC_MISC:   begin info.cls = CLS_MISC;   info.fmt = IMM_I; end
      OPC_SYSTEM: begin info.cls = CLS_SYSTEM; info.fmt = IMM_I; end
      default:    info.illegal = 1'b1;
    endcase
    return info;
  endfunction

endpackage
`endif

// File: rtl/instr_decode_stage_imm_gen.sv
// Combinational immediate generator: instruction bits [31:7] + format select
// -> sign-extended DWIDTH immediate (zero for formats without an immediate).
//   instr : instruction word bits [31:7] (opcode bits are not needed)
//   fmt   : immediate format select
//   imm   : sign-extended immediate
module instr_decode_stage_imm_gen
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [31:7]       instr,
  input  imm_fmt_e          fmt,
  output logic [DWIDTH-1:0] imm
);

  // Each format is assembled as a signed field, then the sized cast sign-extends it.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = DWIDTH'($signed(instr[31:20]));
      IMM_S:   imm = DWIDTH'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm = DWIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:   imm = DWIDTH'($signed({instr[31:12], 12'b0}));
      IMM_J:   imm = DWIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage in front of the register file. Register read addresses
// are driven combinationally in the accept cycle so registered read data lines
// up with d_o_valid; decoded fields sit in a one-entry valid/ready register.
//   d_clk, d_rst               : clock, async active-low reset
//   d_i_valid/d_i_ready        : fetch-side handshake, d_i_instr/d_i_pc payload
//   d_flush                    : kills held and incoming instruction
//   d_o_valid/d_o_ready        : execute-side handshake
//   d_addr_rs1/d_addr_rs2      : regfile read addresses (combinational)
//   d_o_pc ... d_o_illegal     : registered decoded fields
module instr_decode_stage #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned IWIDTH = 32
) (
  input  logic              d_clk,
  input  logic              d_rst,
  input  logic              d_i_valid,
  output logic              d_i_ready,
  input  logic [IWIDTH-1:0] d_i_instr,
  input  logic [DWIDTH-1:0] d_i_pc,
  input  logic              d_flush,
  output logic              d_o_valid,
  input  logic              d_o_ready,
  output logic [AWIDTH-1:0] d_addr_rs1,
  output logic [AWIDTH-1:0] d_addr_rs2,
  output logic [DWIDTH-1:0] d_o_pc,
  output logic [AWIDTH-1:0] d_o_rd,
  output logic [DWIDTH-1:0] d_o_imm,
  output logic [3:0]        d_o_class,
  output logic [2:0]        d_o_funct3,
  output logic              d_o_funct7b5,
  output logic              d_o_we,
  output logic              d_o_illegal
);
  import instr_decode_stage_pkg::*;

  op_info_t          info;
  logic              accept;
  logic              we_new;
  logic [AWIDTH-1:0] rs1_new;
  logic [AWIDTH-1:0] rs2_new;
  logic [AWIDTH-1:0] rs1_q;
  logic [AWIDTH-1:0] rs2_q;
  logic [AWIDTH-1:0] rd_field;
  logic [DWIDTH-1:0] imm_new;

  assign info = decode_opcode(d_i_instr[6:0]);

  // Handshake: flush frees the slot, so fetch sees ready even while stalled.
  assign d_i_ready = ~d_o_valid | d_o_ready | d_flush;
  assign accept    = d_i_valid & d_i_ready & ~d_flush;

  // Unused source fields are forced to x0 so the regfile never reads garbage.
  assign rs1_new = info.rs1_used ? AWIDTH'(d_i_instr[19:15]) : '0;
  assign rs2_new = info.rs2_used ? AWIDTH'(d_i_instr[24:20]) : '0;

  // The regfile re-reads every cycle, so a stalled entry keeps presenting its sources.
  assign d_addr_rs1 = (accept | ~d_o_valid) ? rs1_new : rs1_q;
  assign d_addr_rs2 = (accept | ~d_o_valid) ? rs2_new : rs2_q;

  assign rd_field = AWIDTH'(d_i_instr[11:7]);
  assign we_new   = info.writes_rd & (rd_field != '0);

  instr_decode_stage_imm_gen #(
    .DWIDTH (DWIDTH)
  ) u_imm_gen (
    .instr (d_i_instr[31:7]),
    .fmt   (info.fmt),
    .imm   (imm_new)
  );

  // One-entry pipeline register: flush > accept > drain > hold.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      d_o_valid    <= 1'b0;
      d_o_pc       <= '0;
      d_o_rd       <= '0;
      d_o_imm      <= '0;
      d_o_class    <= '0;
      d_o_funct3   <= '0;
      d_o_funct7b5 <= 1'b0;
      d_o_we       <= 1'b0;
      d_o_illegal  <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
    end else if (d_flush) begin
      d_o_valid <= 1'b0;
    end else if (accept) begin
      d_o_valid    <= 1'b1;
      d_o_pc       <= d_i_pc;
      d_o_rd       <= we_new ? rd_field : '0;
      d_o_imm      <= imm_new;
      d_o_class    <= info.cls;
      d_o_funct3   <= d_i_instr[14:12];
      d_o_funct7b5 <= d_i_instr[30];
      d_o_we       <= we_new;
      d_o_illegal  <= info.illegal;
      rs1_q        <= rs1_new;
      rs2_q        <= rs2_new;
    end else if (d_o_ready) begin
      d_o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  logic        d_clk;
  logic        d_rst;
  logic        d_i_valid;
  logic        d_i_ready;
  logic [31:0] d_i_instr;
  logic [31:0] d_i_pc;
  logic        d_flush;
  logic        d_o_valid;
  logic        d_o_ready;
  logic [4:0]  d_addr_rs1;
  logic [4:0]  d_addr_rs2;
  logic [31:0] d_o_pc;
  logic [4:0]  d_o_rd;
  logic [31:0] d_o_imm;
  logic [3:0]  d_o_class;
  logic [2:0]  d_o_funct3;
  logic        d_o_funct7b5;
  logic        d_o_we;
  logic        d_o_illegal;

  instr_decode_stage #(.DWIDTH(32), .AWIDTH(5), .IWIDTH(32)) dut (
    .d_clk        (d_clk),
    .d_rst        (d_rst),
    .d_i_valid    (d_i_valid),
    .d_i_ready    (d_i_ready),
    .d_i_instr    (d_i_instr),
    .d_i_pc       (d_i_pc),
    .d_flush      (d_flush),
    .d_o_valid    (d_o_valid),
    .d_o_ready    (d_o_ready),
    .d_addr_rs1   (d_addr_rs1),
    .d_addr_rs2   (d_addr_rs2),
    .d_o_pc       (d_o_pc),
    .d_o_rd       (d_o_rd),
    .d_o_imm      (d_o_imm),
    .d_o_class    (d_o_class),
    .d_o_funct3   (d_o_funct3),
    .d_o_funct7b5 (d_o_funct7b5),
    .d_o_we       (d_o_we),
    .d_o_illegal  (d_o_illegal)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic        we;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] I_ADDI  = 32'hFFF08293; // addi x5,x1,-1
  localparam logic [31:0] I_BEQ   = 32'hFE208EE3; // beq x1,x2,-4
  localparam logic [31:0] I_ADD   = 32'h005201B3; // add x3,x4,x5
  localparam logic [31:0] I_SUB   = 32'h40838333; // sub x6,x7,x8
  localparam logic [31:0] I_LW    = 32'h00412383; // lw x7,4(x2)
  localparam logic [31:0] I_NOP   = 32'h00000013;
  localparam logic [31:0] I_ZERO  = 32'h00000000;
  localparam logic [31:0] I_LUI   = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_LUI0  = 32'h00001037; // lui x0,1
  localparam logic [31:0] I_JAL   = 32'h008000EF; // jal x1,8
  localparam logic [31:0] I_SW    = 32'hFE512C23; // sw x5,-8(x2)
  localparam logic [31:0] I_JALR  = 32'h000280E7; // jalr x1,0(x5)
  localparam logic [31:0] I_AUIPC = 32'hFFFFF517; // auipc x10,0xfffff
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_FENCE = 32'h0FF0000F;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA encoding tables.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic keep_rs1, keep_rs2, can_write;
    e = '0;
    e.pc = pc; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    keep_rs1 = 1'b1; keep_rs2 = 1'b0; can_write = 1'b0;
    case (ins[6:0])
      7'h37: begin e.cls = CLS_LUI;    e.imm = ins & 32'hFFFFF000; keep_rs1 = 1'b0; can_write = 1'b1; end
      7'h17: begin e.cls = CLS_AUIPC;  e.imm = ins & 32'hFFFFF000; keep_rs1 = 1'b0; can_write = 1'b1; end
      7'h6F: begin e.cls = CLS_JAL;    e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); keep_rs1 = 1'b0; can_write = 1'b1; end
      7'h67: begin e.cls = CLS_JALR;   e.imm = 32'($signed(ins) >>> 20); can_write = 1'b1; end
      7'h63: begin e.cls = CLS_BRANCH; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); keep_rs2 = 1'b1; end
      7'h03: begin e.cls = CLS_LOAD;   e.imm = 32'($signed(ins) >>> 20); can_write = 1'b1; end
      7'h23: begin e.cls = CLS_STORE;  e.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | {27'b0, ins[11:7]}; keep_rs2 = 1'b1; end
      7'h13: begin e.cls = CLS_OPIMM;  e.imm = 32'($signed(ins) >>> 20); can_write = 1'b1; end
      7'h33: begin e.cls = CLS_OP;     e.imm = 32'h0; keep_rs2 = 1'b1; can_write = 1'b1; end
      7'h0F: begin e.cls = CLS_MISC;   e.imm = 32'($signed(ins) >>> 20); end
      7'h73: begin e.cls = CLS_SYSTEM; e.imm = 32'($signed(ins) >>> 20); end
      default: begin e.cls = CLS_ILLEGAL; e.ill = 1'b1; e.imm = 32'h0; end
    endcase
    e.we  = can_write && (ins[11:7] != 5'd0);
    e.rd  = e.we ? ins[11:7] : 5'd0;
    e.rs1 = keep_rs1 ? ins[19:15] : 5'd0;
    e.rs2 = keep_rs2 ? ins[24:20] : 5'd0;
    return e;
  endfunction

  // One clock: drive at the falling edge, check after settling, update scoreboard.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    exp_t nxt, held;
    logic mvalid, exp_rdy, acc;
    d_i_valid = v; d_i_instr = ins; d_i_pc = pc; d_o_ready = rdy; d_flush = fl;
    #1;
    mvalid  = (q.size() != 0);
    exp_rdy = !mvalid || rdy || fl;
    acc     = v && exp_rdy && !fl;
    nxt     = model(ins, pc);
    chk("i_ready", 32'(d_i_ready), 32'(exp_rdy));
    chk("o_valid", 32'(d_o_valid), 32'(mvalid));
    if (mvalid) begin
      held = q[0];
      chk("o_pc",      d_o_pc,              held.pc);
      chk("o_rd",      32'(d_o_rd),         32'(held.rd));
      chk("o_imm",     d_o_imm,             held.imm);
      chk("o_class",   32'(d_o_class),      32'(held.cls));
      chk("o_funct3",  32'(d_o_funct3),     32'(held.f3));
      chk("o_funct7b5",32'(d_o_funct7b5),   32'(held.f7b5));
      chk("o_we",      32'(d_o_we),         32'(held.we));
      chk("o_illegal", 32'(d_o_illegal),    32'(held.ill));
    end else begin
      held = nxt;
    end
    chk("addr_rs1", 32'(d_addr_rs1), 32'((acc || !mvalid) ? nxt.rs1 : held.rs1));
    chk("addr_rs2", 32'(d_addr_rs2), 32'((acc || !mvalid) ? nxt.rs2 : held.rs2));
    if (mvalid && (fl || rdy)) void'(q.pop_front());
    if (acc) q.push_back(nxt);
    @(negedge d_clk);
  endtask

  initial begin
    d_rst = 1'b0; d_i_valid = 1'b0; d_i_instr = '0; d_i_pc = '0;
    d_flush = 1'b0; d_o_ready = 1'b0;
    repeat (2) @(negedge d_clk);
    chk("rst_valid", 32'(d_o_valid), 32'h0);
    chk("rst_imm",   d_o_imm,        32'h0);
    chk("rst_ready", 32'(d_i_ready), 32'h1);
    chk("rst_we",    32'(d_o_we),    32'h0);
    d_rst = 1'b1;
    @(negedge d_clk);

    // ADDI: rs1 presented in the accept cycle, fields one cycle later
    step(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0);
    chk("addi_rd",  32'(d_o_rd), 32'd5);
    chk("addi_imm", d_o_imm,     32'hFFFFFFFF);
    chk("addi_we",  32'(d_o_we), 32'h1);

    // BEQ: both sources, no writeback
    step(1'b1, I_BEQ, 32'h104, 1'b1, 1'b0);
    chk("beq_imm", d_o_imm,     32'hFFFFFFFC);
    chk("beq_we",  32'(d_o_we), 32'h0);
    chk("beq_rd",  32'(d_o_rd), 32'h0);

    // Stall three cycles with a new instruction waiting
    step(1'b1, I_ADD, 32'h108, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, I_SUB, 32'h10C, 1'b0, 1'b0);
      chk("stall_ready", 32'(d_i_ready),  32'h0);
      chk("stall_rs1",   32'(d_addr_rs1), 32'd4);
      chk("stall_rs2",   32'(d_addr_rs2), 32'd5);
      chk("stall_pc",    d_o_pc,          32'h108);
    end
    step(1'b1, I_SUB, 32'h10C, 1'b1, 1'b0);
    chk("resume_pc", d_o_pc, 32'h10C);

    // Flush while output held and input valid
    step(1'b1, I_LW, 32'h110, 1'b0, 1'b1);
    chk("flush_valid", 32'(d_o_valid), 32'h0);
    step(1'b0, I_NOP, 32'h0, 1'b1, 1'b0);

    // Illegal word, then canonical NOP
    step(1'b1, I_ZERO, 32'h200, 1'b1, 1'b0);
    chk("ill_flag", 32'(d_o_illegal), 32'h1);
    chk("ill_we",   32'(d_o_we),      32'h0);
    chk("ill_imm",  d_o_imm,          32'h0);
    step(1'b1, I_NOP, 32'h204, 1'b1, 1'b0);
    chk("nop_ill", 32'(d_o_illegal), 32'h0);
    chk("nop_we",  32'(d_o_we),      32'h0);

    // Remaining formats and rd=x0 / forced-x0 source cases
    step(1'b1, I_LUI,   32'h208, 1'b1, 1'b0);
    chk("lui_imm", d_o_imm, 32'h12345000);
    step(1'b1, I_LUI0,  32'h20C, 1'b1, 1'b0);
    step(1'b1, I_JAL,   32'h210, 1'b1, 1'b0);
    chk("jal_imm", d_o_imm, 32'h8);
    step(1'b1, I_SW,    32'h214, 1'b1, 1'b0);
    chk("sw_imm", d_o_imm, 32'hFFFFFFF8);
    step(1'b1, I_JALR,  32'h218, 1'b1, 1'b0);
    step(1'b1, I_AUIPC, 32'h21C, 1'b1, 1'b0);
    step(1'b1, I_ECALL, 32'h220, 1'b1, 1'b0);
    step(1'b1, I_FENCE, 32'h224, 1'b1, 1'b0);
    step(1'b1, I_LW,    32'h228, 1'b1, 1'b0);
    step(1'b0, I_NOP,   32'h0,   1'b1, 1'b0);

    // Reset mid-stall: outputs clear immediately, held instruction lost
    step(1'b1, I_LW,  32'h300, 1'b1, 1'b0);
    step(1'b1, I_ADD, 32'h304, 1'b0, 1'b0);
    d_rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(d_o_valid), 32'h0);
    chk("mrst_imm",   d_o_imm,        32'h0);
    chk("mrst_pc",    d_o_pc,         32'h0);
    chk("mrst_ready", 32'(d_i_ready), 32'h1);
    q.delete();
    @(negedge d_clk);
    d_rst = 1'b1;
    step(1'b0, I_NOP,  32'h0,   1'b1, 1'b0);
    step(1'b1, I_ADDI, 32'h400, 1'b1, 1'b0);
    step(1'b0, I_NOP,  32'h0,   1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
